// File: rtl/seq_tx.sv
// seq_tx: framed serial transmitter.
// Each accepted payload goes out as: sync PATTERN (MSB first), payload
// (MSB first), an optional even-parity bit, then GAP_LEN forced-0 idle bits.
// Optional feature macro: SEQ_TX_PARITY_EN adds the PAR state and parity bit.
// All outputs except in_ready are registered. Their values are computed from
// the next state and next count, so they line up with the state they describe.
module seq_tx #(
   parameter int                   PATTERN_W = 5,
   parameter logic [PATTERN_W-1:0] PATTERN   = 5'b11011,
   parameter int                   PAYLOAD_W = 8,
   parameter int                   GAP_LEN   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [PAYLOAD_W-1:0] in_data,
   output logic                 in_ready,
   output logic                 tx_out,
   output logic                 tx_en,
   output logic                 frame_done
);

   localparam int MAX_AB = (PATTERN_W > PAYLOAD_W) ? PATTERN_W : PAYLOAD_W;
   localparam int MAX_V  = (MAX_AB > GAP_LEN) ? MAX_AB : GAP_LEN;
   localparam int CNT_W  = (MAX_V > 1) ? $clog2(MAX_V) : 1;

   localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(PATTERN_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(PAYLOAD_W - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SYNC = 3'd1,
      S_DATA = 3'd2,
`ifdef SEQ_TX_PARITY_EN
      S_PAR  = 3'd3,
`endif
      S_GAP  = 3'd4
   } state_t;

`ifdef SEQ_TX_PARITY_EN
   // Even parity: XOR of all payload bits.
   function automatic logic even_parity(input logic [PAYLOAD_W-1:0] d);
      return ^d;
   endfunction
`endif

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [CNT_W-1:0]       r_cnt;
   logic [CNT_W-1:0]       w_cnt_nxt;
   logic [PAYLOAD_W-1:0]   r_payload;
   logic                   r_tx_out;
   logic                   r_tx_en;
   logic                   r_frame_done;
   logic                   w_accept;
   logic                   w_bit;
   logic                   w_en;
   logic                   w_done;

   // Reset blocks an accept, even when in_valid is high.
   assign w_accept   = in_valid && (r_state == S_IDLE) && !rst;
   assign in_ready   = (r_state == S_IDLE);
   assign tx_out     = r_tx_out;
   assign tx_en      = r_tx_en;
   assign frame_done = r_frame_done;

   // Next-state and bit-counter logic; the counter restarts at 0 on every state change.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_SYNC;
               w_cnt_nxt   = {CNT_W{1'b0}};
            end else begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = {CNT_W{1'b0}};
            end
         end
         S_SYNC: begin
            if (r_cnt == SYNC_LAST) begin
               w_state_nxt = S_DATA;
               w_cnt_nxt   = {CNT_W{1'b0}};
            end else begin
               w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (r_cnt == DATA_LAST) begin
`ifdef SEQ_TX_PARITY_EN
               w_state_nxt = S_PAR;
`else
               w_state_nxt = S_GAP;
`endif
               w_cnt_nxt   = {CNT_W{1'b0}};
            end else begin
               w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
         end
`ifdef SEQ_TX_PARITY_EN
         S_PAR: begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = {CNT_W{1'b0}};
         end
`endif
         S_GAP: begin
            if (r_cnt == GAP_LAST) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = {CNT_W{1'b0}};
            end else begin
               w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = {CNT_W{1'b0}};
         end
      endcase
   end

   // Output values for the cycle that begins at the next edge.
   always_comb begin
      w_bit  = 1'b0;
      w_en   = 1'b0;
      w_done = 1'b0;
      case (w_state_nxt)
         S_SYNC: begin
            w_en = 1'b1;
            for (int i = 0; i < PATTERN_W; i++) begin
               w_bit = (w_cnt_nxt == CNT_W'(PATTERN_W - 1 - i)) ? PATTERN[i] : w_bit;
            end
         end
         S_DATA: begin
            w_en = 1'b1;
            for (int i = 0; i < PAYLOAD_W; i++) begin
               w_bit = (w_cnt_nxt == CNT_W'(PAYLOAD_W - 1 - i)) ? r_payload[i] : w_bit;
            end
         end
`ifdef SEQ_TX_PARITY_EN
         S_PAR: begin
            w_en  = 1'b1;
            w_bit = even_parity(r_payload);
         end
`endif
         S_GAP: begin
            w_done = (w_cnt_nxt == GAP_LAST);
         end
         default: begin
            w_bit  = 1'b0;
            w_en   = 1'b0;
            w_done = 1'b0;
         end
      endcase
   end

   // State, counter, payload latch and registered serial outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= {CNT_W{1'b0}};
         r_payload    <= {PAYLOAD_W{1'b0}};
         r_tx_out     <= 1'b0;
         r_tx_en      <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_tx_out     <= w_bit;
         r_tx_en      <= w_en;
         r_frame_done <= w_done;
         if (w_accept) begin
            r_payload <= in_data;
         end else begin
            r_payload <= r_payload;
         end
      end
   end

endmodule
